// File: rtl/erroneous_gate_array_pkg.sv
// Shared types, constants and LFSR helpers for the erroneous gate array.
package erroneous_pkg;

    typedef enum logic [1:0] {
        OP_NAND = 2'd0,
        OP_NOR  = 2'd1,
        OP_XOR  = 2'd2,
        OP_AND  = 2'd3
    } gate_op_e;

    typedef enum logic {
        CH_GOOD = 1'b0,
        CH_BAD  = 1'b1
    } chan_state_e;

    localparam logic [31:0] LFSR_POLY   = 32'h8020_0003;
    localparam logic [31:0] LFSR_GOLDEN = 32'h9E37_79B9;

    // Right-shifting Galois step for x^32+x^22+x^2+x+1.
    function automatic logic [31:0] lfsr_next(input logic [31:0] s);
        return s[0] ? ((s >> 1) ^ LFSR_POLY) : (s >> 1);
    endfunction

    // An all-zero LFSR would lock up, so zero seeds become 1.
    function automatic logic [31:0] seed_guard(input logic [31:0] s);
        return (s == 32'h0) ? 32'h1 : s;
    endfunction

endpackage

// File: rtl/err_lfsr.sv
// One 32-bit Galois LFSR that raises flip when its low THR_W bits fall below thr.
module err_lfsr
    import erroneous_pkg::*;
#(
    parameter logic [31:0] SEED  = 32'h1,
    parameter int          THR_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    input  logic [THR_W-1:0] thr,
    output logic             flip
);

    logic [31:0] r_lfsr;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_lfsr <= seed_guard(SEED);
        end else if (en) begin
            r_lfsr <= lfsr_next(r_lfsr);
        end
    end

    // The decision uses the value before this cycle's advance.
    assign flip = (r_lfsr[THR_W-1:0] < thr);

endmodule

// File: rtl/erroneous_gate_array.sv
// WIDTH lanes of 2-input gates with bursty (Gilbert-Elliott) random bit flips.
// Optional macro ERR_FORCE_EN adds force_mask_i to force flips on chosen lanes.
module erroneous_gate_array
    import erroneous_pkg::*;
#(
    parameter int               WIDTH      = 8,
    parameter int               THR_W      = 16,
    parameter logic [THR_W-1:0] P_ERR_GOOD = 16'd655,
    parameter logic [THR_W-1:0] P_ERR_BAD  = 16'd16384,
    parameter logic [THR_W-1:0] P_G2B      = 16'd328,
    parameter logic [THR_W-1:0] P_B2G      = 16'd6554,
    parameter logic [31:0]      LFSR_SEED  = 32'hACE1_1234,
    parameter int               CNT_W      = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             valid_i,
    input  logic [1:0]       op_i,
    input  logic [WIDTH-1:0] x_i,
    input  logic [WIDTH-1:0] y_i,
    input  logic             inject_en_i,
    input  logic             clear_cnt_i,
`ifdef ERR_FORCE_EN
    input  logic [WIDTH-1:0] force_mask_i,
`endif
    output logic             valid_o,
    output logic [WIDTH-1:0] z_o,
    output logic [WIDTH-1:0] err_mask_o,
    output logic             burst_o,
    output logic [CNT_W-1:0] err_cnt_o,
    output logic             chan_state_o
);

    localparam int POP_W = $clog2(WIDTH + 1);

    chan_state_e      r_state;
    logic             r_valid;
    logic [WIDTH-1:0] r_z;
    logic [WIDTH-1:0] r_mask;
    logic             r_burst;
    logic [CNT_W-1:0] r_cnt;

    logic [THR_W-1:0] w_lane_thr;
    logic [THR_W-1:0] w_chan_thr;
    logic [WIDTH-1:0] w_lane_flip;
    logic             w_chan_flip;
    logic [WIDTH-1:0] w_force;
    logic [WIDTH-1:0] w_flip_mask;
    logic [WIDTH-1:0] w_gate;
    logic [POP_W-1:0] w_pop;
    logic [CNT_W:0]   w_sum;
    logic [CNT_W-1:0] w_cnt_next;

    assign w_lane_thr = (r_state == CH_BAD) ? P_ERR_BAD : P_ERR_GOOD;
    assign w_chan_thr = (r_state == CH_BAD) ? P_B2G : P_G2B;

    genvar gi;
    for (gi = 0; gi < WIDTH; gi++) begin : g_lane
        localparam logic [31:0] LANE_SEED = LFSR_SEED ^ 32'(32'(gi) * LFSR_GOLDEN);
        err_lfsr #(
            .SEED  (LANE_SEED),
            .THR_W (THR_W)
        ) u_lfsr (
            .clk     (clk),
            .reset_n (reset_n),
            .en      (valid_i),
            .thr     (w_lane_thr),
            .flip    (w_lane_flip[gi])
        );
    end

    err_lfsr #(
        .SEED  (~LFSR_SEED),
        .THR_W (THR_W)
    ) u_chan_lfsr (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (valid_i),
        .thr     (w_chan_thr),
        .flip    (w_chan_flip)
    );

`ifdef ERR_FORCE_EN
    // Forced flips bypass inject_en_i; only valid_i gates them.
    assign w_force = valid_i ? force_mask_i : '0;
`else
    assign w_force = '0;
`endif

    assign w_flip_mask = ((valid_i && inject_en_i) ? w_lane_flip : '0) | w_force;

    always_comb begin
        w_gate = '0;
        case (gate_op_e'(op_i))
            OP_NAND: w_gate = ~(x_i & y_i);
            OP_NOR:  w_gate = ~(x_i | y_i);
            OP_XOR:  w_gate = x_i ^ y_i;
            OP_AND:  w_gate = x_i & y_i;
            default: w_gate = '0;
        endcase
    end

    always_comb begin
        w_pop = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_pop = w_pop + POP_W'(w_flip_mask[i]);
        end
    end

    // One extra bit catches the carry so the counter saturates instead of wrapping.
    assign w_sum      = (CNT_W+1)'(r_cnt) + (CNT_W+1)'(w_pop);
    assign w_cnt_next = w_sum[CNT_W] ? '1 : w_sum[CNT_W-1:0];

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= CH_GOOD;
            r_valid <= 1'b0;
            r_z     <= '0;
            r_mask  <= '0;
            r_burst <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_valid <= valid_i;
            if (valid_i) begin
                r_z     <= w_gate ^ w_flip_mask;
                r_mask  <= w_flip_mask;
                r_burst <= (r_state == CH_BAD);
                if (w_chan_flip) begin
                    r_state <= (r_state == CH_GOOD) ? CH_BAD : CH_GOOD;
                end
            end
            r_cnt <= clear_cnt_i ? '0 : w_cnt_next;
        end
    end

    assign valid_o      = r_valid;
    assign z_o          = r_z;
    assign err_mask_o   = r_mask;
    assign burst_o      = r_burst;
    assign err_cnt_o    = r_cnt;
    assign chan_state_o = (r_state == CH_BAD);

endmodule

// File: doc/erroneous_gate_array.md
Name: erroneous_gate_array

Overview:
- WIDTH-lane array of unreliable 2-input gates for the reliable-logic simulation fabric.
- Each lane computes a runtime-selected Boolean op, then XORs a per-lane pseudo-random error bit; the result is registered.
- Errors follow a two-state Gilbert-Elliott channel (GOOD/BAD) to model bursty faults.
- LFSR-based randomness is deterministic and synthesizable; no $dist_* calls. Used as the building block for multiplexed/restoring redundancy experiments.

Parameters:
- WIDTH, 8, number of gate lanes.
- THR_W, 16, error-threshold width; per-flip probability = thr / 2^THR_W.
- P_ERR_GOOD, 16'd655, per-lane flip threshold in GOOD state (~1%).
- P_ERR_BAD, 16'd16384, per-lane flip threshold in BAD state (25%).
- P_G2B, 16'd328, GOOD->BAD transition threshold per accepted op.
- P_B2G, 16'd6554, BAD->GOOD transition threshold per accepted op.
- LFSR_SEED, 32'hACE1_1234, base seed (nonzero).
- CNT_W, 16, error-counter width.

Ports:
- clk  in  1  clock.
- reset_n  in  1  synchronous active-low reset.
- valid_i  in  1  operands valid this cycle; only accepted ops advance state.
- op_i  in  2  gate op: 0 NAND, 1 NOR, 2 XOR, 3 AND.
- x_i  in  WIDTH  operand A.
- y_i  in  WIDTH  operand B.
- inject_en_i  in  1  0 = ideal gates (no flips, LFSRs still advance).
- clear_cnt_i  in  1  clear the error counter.
- valid_o  out  1  z_o/err_mask_o valid.
- z_o  out  WIDTH  registered (possibly erroneous) result.
- err_mask_o  out  WIDTH  lanes flipped for this result.
- burst_o  out  1  channel state used for this result (1 = BAD).
- err_cnt_o  out  CNT_W  saturating count of flipped bits.

Behaviour:
- Reset (reset_n=0 at posedge):
  - valid_o, z_o, err_mask_o, burst_o and err_cnt_o all go to 0; channel state goes to GOOD.
  - Lane LFSR i is loaded with LFSR_SEED ^ (i * 32'h9E3779B9); a zero result is replaced by 32'h1.
  - The channel LFSR is loaded with ~LFSR_SEED, with the same zero guard.
  - Reset asserted mid-stream discards the in-flight result.
- LFSR: 32-bit Galois, polynomial x^32+x^22+x^2+x+1 (mask 32'h8020_0003). Every LFSR advances exactly one step per cycle with valid_i=1 and holds otherwise.
- Decisions use the current (pre-advance) LFSR value's low THR_W bits as r. A lane flips iff inject_en_i && r < thr, where thr is P_ERR_GOOD or P_ERR_BAD according to the current state. thr=0 never flips.
- Channel FSM (advances only on accepted ops; uses channel LFSR r):
  - GOOD->BAD iff r < P_G2B.
  - BAD->GOOD iff r < P_B2G.
  - The new state applies to the next accepted op. The current op uses the current state.
- Latency 1 cycle. valid_o(t+1) = valid_i(t). When valid_i=0, z_o, err_mask_o and burst_o hold their previous values.
- z_o = op(x_i, y_i) ^ flip_mask. err_mask_o = flip_mask. burst_o = state used for the op.
- Counter:
  - Adds popcount(flip_mask) per accepted op and saturates at all-ones (no wrap).
  - clear_cnt_i has priority: when asserted, the next value is 0 and the same-cycle increment is dropped.

Optional Feature:
- Macro ERR_FORCE_EN.
- Defined: adds input force_mask_i [WIDTH]. Final flip_mask = random_mask | force_mask_i, gated by valid_i only (forces apply even with inject_en_i=0). Forced flips are counted and reported in err_mask_o.
- Undefined: port absent; behaviour as above.

Decomposition:
- Package erroneous_pkg holds:
  - gate_op_e enum (OP_NAND, OP_NOR, OP_XOR, OP_AND);
  - chan_state_e (CH_GOOD, CH_BAD);
  - LFSR_POLY = 32'h8020_0003;
  - LFSR_GOLDEN = 32'h9E3779B9;
  - function lfsr_next(logic [31:0]).
- Sub-module err_lfsr (params SEED, THR_W): en input, thr input, flip output, registered state. Instantiated WIDTH times for the lanes plus once for the channel FSM.

Test Plan:
- Reset then idle 10 cycles, valid_i=0 -> valid_o=0, z_o=0, err_cnt_o=0, burst_o=0, LFSRs unchanged.
- inject_en_i=0, op=NAND, x=8'hF0, y=8'hCC -> next cycle z_o=8'h3F, err_mask_o=0. Repeat for NOR, XOR, AND: 8'h03, 8'h3C, 8'hC0.
- P_ERR_GOOD=P_ERR_BAD=16'hFFFF, P_G2B=0, inject on, op=AND, x=y=8'hFF -> z_o=8'h00 (flip iff r<16'hFFFF), err_mask_o=8'hFF, err_cnt_o increments by 8 per op; with CNT_W=4 the counter saturates at 15.
- Default params, 100000 accepted ops -> GOOD-state flip rate 1%±0.2%, BAD 25%±1%. Identical LFSR_SEED gives a bit-identical z_o trace to the golden model.
- clear_cnt_i asserted in the same cycle as an op with 3 flips -> err_cnt_o=0 next cycle. Reset asserted while valid_o pending -> valid_o=0 and state GOOD next cycle.
- ERR_FORCE_EN defined, inject_en_i=0, force_mask_i=8'h81, NAND x=y=0 -> z_o=8'h7E, err_mask_o=8'h81, err_cnt_o += 2.
